// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial adder controller. Presents one operand bit pair
//               plus running carry per cycle to an external combinational
//               1-bit full adder, LSB first, and assembles the WIDTH-bit sum
//               and final carry-out. Latency is WIDTH RUN cycles plus a
//               single DONE cycle that carries the done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_ci,
    input  logic             fa_s,
    input  logic             fa_co,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                 c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_busy;
    logic               r_done;
    logic               w_run;

    // The adder only sees live operand bits while RUN; otherwise it sees zeros.
    assign w_run = (r_state == c_RUN);
    assign fa_a  = w_run & r_a[0];
    assign fa_b  = w_run & r_b[0];
    assign fa_ci = w_run & r_carry;

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

    // Sequencer: capture operands, shift one bit per RUN cycle, then pulse done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    // Sum bits enter at the MSB so that after WIDTH shifts
                    // the first (LSB) result bit has reached position 0.
                    r_sum   <= {fa_s, r_sum[WIDTH-1:1]};
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_carry <= fa_co;
                    r_cnt   <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_LAST) begin
                        r_cout  <= fa_co;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    // Start is deliberately ignored here; a held start is
                    // picked up on the following IDLE cycle.
                    r_done  <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Self-checking bench for serial_add_ctrl with a behavioural
//               full adder on the fa_* ports and an arithmetic reference
//               model compared against the DUT on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             fa_a;
    logic             fa_b;
    logic             fa_ci;
    logic             fa_s;
    logic             fa_co;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural external full adder
    assign fa_s  = fa_a ^ fa_b ^ fa_ci;
    assign fa_co = (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .fa_a  (fa_a),
        .fa_b  (fa_b),
        .fa_ci (fa_ci),
        .fa_s  (fa_s),
        .fa_co (fa_co),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: tracks edges since an accepted start and computes
    // the result as plain a+b+cin; the carry into bit k is derived from
    // the sum of the low k bits of the operands.
    // ------------------------------------------------------------------
    bit               m_active = 0;
    int               m_k      = 0;
    logic [WIDTH-1:0] m_a      = '0;
    logic [WIDTH-1:0] m_b      = '0;
    logic             m_c      = 1'b0;
    logic [WIDTH-1:0] m_sum    = '0;
    logic             m_cout   = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_active = 0;
                m_k      = 0;
                m_sum    = '0;
                m_cout   = 1'b0;
            end else if (!m_active) begin
                if (start) begin
                    m_active = 1;
                    m_k      = 0;
                    m_a      = a;
                    m_b      = b;
                    m_c      = cin;
                end
            end else begin
                m_k++;
                if (m_k == WIDTH) begin
                    {m_cout, m_sum} = {1'b0, m_a} + {1'b0, m_b} + {{WIDTH{1'b0}}, m_c};
                end
                if (m_k == WIDTH + 1) m_active = 0;
            end
            #1;
            begin
                bit exp_busy;
                bit exp_done;
                int mask;
                int low;
                exp_busy = m_active && (m_k < WIDTH);
                exp_done = m_active && (m_k == WIDTH);
                chk("busy", {31'd0, busy}, {31'd0, exp_busy});
                chk("done", {31'd0, done}, {31'd0, exp_done});
                if (exp_busy) begin
                    mask = (1 << m_k) - 1;
                    low  = (int'(m_a) & mask) + (int'(m_b) & mask) + int'(m_c);
                    chk("fa_a",  {31'd0, fa_a},  {31'd0, m_a[m_k]});
                    chk("fa_b",  {31'd0, fa_b},  {31'd0, m_b[m_k]});
                    chk("fa_ci", {31'd0, fa_ci}, 32'((low >> m_k) & 1));
                end else begin
                    chk("fa_idle", {29'd0, fa_a, fa_b, fa_ci}, 32'd0);
                    chk("sum",  {24'd0, sum},  {24'd0, m_sum});
                    chk("cout", {31'd0, cout}, {31'd0, m_cout});
                end
            end
        end
    end

    // One operation with literal expectations; optionally fires a second
    // start with different operands while the first is running.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                          input logic [7:0] es, input logic ec, input string nm,
                          input bit inject);
        int  n;
        int  nbusy;
        bit  seen;
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_v; cin = tc;
        @(negedge clk);
        start = 1'b0;
        nbusy = 0;
        seen  = 0;
        for (n = 1; n <= 30; n++) begin
            if (inject && n == 3) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
            end else if (inject && n == 4) begin
                start = 1'b0;
            end
            if (busy) nbusy++;
            if (done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk({nm, "_done_seen"}, {31'd0, seen}, 32'd1);
        chk({nm, "_latency"}, n, 9);
        chk({nm, "_busy_cycles"}, nbusy, 8);
        chk({nm, "_sum"}, {24'd0, sum}, {24'd0, es});
        chk({nm, "_cout"}, {31'd0, cout}, {31'd0, ec});
        @(negedge clk);
        chk({nm, "_single_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int ndone;
        int gap;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum",  {24'd0, sum},  32'd0);
        chk("rst_fa",   {29'd0, fa_a, fa_b, fa_ci}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "zero",  0);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "wrap",  0);
        run_op(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, "plain", 0);
        run_op(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "cin",   0);
        run_op(8'h11, 8'h22, 1'b0, 8'h33, 1'b0, "ignore", 1);
        // No second done from the ignored start
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("ignore_no_extra_done", ndone, 0);

        // Reset asserted mid-RUN
        @(negedge clk);
        start = 1'b1; a = 8'h77; b = 8'h66; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy_before_rst", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_sum",  {24'd0, sum},  32'd0);
        chk("async_rst_fa",   {29'd0, fa_a, fa_b, fa_ci}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("rst_no_done", ndone, 0);
        run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "after_rst", 0);

        // Start held high across two operations
        @(negedge clk);
        start = 1'b1; a = 8'h80; b = 8'h80; cin = 1'b1;
        gap = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (done) begin
                gap = n;
                break;
            end
        end
        chk("b2b_first_latency", gap, 9);
        chk("b2b_first_sum",  {24'd0, sum},  32'h01);
        chk("b2b_first_cout", {31'd0, cout}, 32'd1);
        a = 8'h01; b = 8'h02; cin = 1'b0;
        gap = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (done) begin
                gap = n;
                break;
            end
        end
        chk("b2b_spacing", gap, 10);
        chk("b2b_second_sum",  {24'd0, sum},  32'h03);
        chk("b2b_second_cout", {31'd0, cout}, 32'd0);
        start = 1'b0;
        repeat (12) @(negedge clk);

        // Randomized traffic, checked by the model every cycle
        repeat (1500) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            a     = WIDTH'($urandom);
            b     = WIDTH'($urandom);
            cin   = 1'($urandom);
            rst_n = ($urandom_range(0, 299) != 0);
        end
        rst_n = 1'b1;
        start = 1'b0;
        repeat (15) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand width in bits (WIDTH >= 2).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port: a  input  WIDTH  operand A; captured when start is accepted.
REQ-006 SHALL have port: b  input  WIDTH  operand B; captured when start is accepted.
REQ-007 SHALL have port: cin  input  1  carry-in; captured when start is accepted.
REQ-008 SHALL have port: fa_a  output  1  bit driven to the external 1-bit full adder's A input.
REQ-009 SHALL have port: fa_b  output  1  bit driven to the external full adder's B input.
REQ-010 SHALL have port: fa_ci  output  1  carry driven to the external full adder's carry-in.
REQ-011 SHALL have port: fa_s  input  1  sum bit returned by the external full adder.
REQ-012 SHALL have port: fa_co  input  1  carry-out returned by the external full adder.
REQ-013 SHALL have port: busy  output  1  high while an addition is in progress.
REQ-014 SHALL have port: done  output  1  one-cycle pulse when the result is valid.
REQ-015 SHALL have port: sum  output  WIDTH  result; held stable from done until the next accepted start.
REQ-016 SHALL have port: cout  output  1  final carry-out; same validity as sum.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE; transitions: IDLE->RUN on start; RUN->DONE after WIDTH RUN cycles; DONE->IDLE unconditionally after one cycle.
REQ-018 SHALL, on the edge where start=1 in IDLE, load a_reg<=a, b_reg<=b, carry<=cin, bit counter<=0, and enter RUN.
REQ-019 SHALL, in RUN, drive fa_a=a_reg[0], fa_b=b_reg[0], fa_ci=carry combinationally; the external adder is purely combinational with zero-cycle latency.
REQ-020 SHALL, on each RUN edge, shift fa_s into the sum shift register at the MSB (shifting right), shift a_reg and b_reg right by one, load carry<=fa_co, and increment the counter.
REQ-021 SHALL, on the RUN edge with counter = WIDTH-1, enter DONE and load cout<=fa_co; after this edge sum[i] = bit i of the result.
REQ-022 SHALL assert done only in DONE (exactly one cycle), i.e. in the cycle after the WIDTH-th RUN edge; total latency from start edge to done high = WIDTH+1 cycles.
REQ-023 SHALL assert busy exactly while in RUN; busy=0 in IDLE and DONE.
REQ-024 SHALL drive fa_a, fa_b, fa_ci to 0 whenever not in RUN.
REQ-025 SHALL ignore start while in RUN or DONE (no re-capture, no effect on the current result).
REQ-026 SHALL keep sum/cout unchanged in IDLE and DONE; they change only during RUN of a new operation.
REQ-027 SHALL, in the case of start=1 held continuously, accept a new operation on the first IDLE cycle after DONE (back-to-back spacing WIDTH+2 cycles).
REQ-028 SHALL compute {cout,sum} = a + b + cin modulo 2^(WIDTH+1), given a correct full adder on the fa_* ports.

Reset
REQ-029 SHALL, while rst_n=0, immediately (asynchronously) force state=IDLE, counter=0, carry=0, a_reg=b_reg=0, sum=0, cout=0, busy=0, done=0, fa_a=fa_b=fa_ci=0.
REQ-030 SHALL abandon any operation in progress when reset is asserted mid-RUN, with no done pulse on release; after rst_n rises, the first start is accepted normally.

Verification (WIDTH=8, bench connects a behavioural full adder to fa_*)
REQ-031 SHALL cover: a=0x00,b=0x00,cin=0 -> done 9 cycles after start edge, sum=0x00, cout=0.
REQ-032 SHALL cover: a=0xFF,b=0x01,cin=0 -> sum=0x00, cout=1; a=0x3C,b=0x0F,cin=0 -> sum=0x4B, cout=0.
REQ-033 SHALL cover: a=0xA5,b=0x5A,cin=1 -> sum=0x00, cout=1; busy high for exactly 8 cycles.
REQ-034 SHALL cover: second start pulse with new operands during RUN -> ignored; result equals the first operation; single done pulse.
REQ-035 SHALL cover: rst_n low at RUN cycle 4 -> busy=0, sum=0, no done; next start with a=0x12,b=0x34,cin=0 -> sum=0x46, cout=0.
REQ-036 SHALL cover: start held high across two operations -> second operation accepted on the IDLE cycle after done; both results correct.
